// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register-file access controller.
package regfile_pkg;

    localparam int REGFILE_WIDTH = 16;
    localparam int REGFILE_NREGS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Request/response bus between a requester (master) and regfile_access_ctrl (slave).
interface regfile_access_ctrl_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = REGFILE_WIDTH,
    parameter int NREGS = REGFILE_NREGS
);
    localparam int AW = $clog2(NREGS);

    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_rs1;
    logic [AW-1:0]    req_rs2;
    logic [AW-1:0]    req_rd;
    logic             req_we;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata1;
    logic [WIDTH-1:0] rsp_rdata2;

    modport master (
        output req_valid, req_rs1, req_rs2, req_rd, req_we, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata1, rsp_rdata2
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_rd, req_we, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata1, rsp_rdata2
    );

endinterface

// File: rtl/regfile_addr_dec.sv
// Address to one-hot row-enable decoder; all-zero output when en is low.
module regfile_addr_dec #(
    parameter int AW    = 3,
    parameter int NREGS = 8
) (
    input  logic             en,
    input  logic [AW-1:0]    addr,
    output logic [NREGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences one read-then-write access per request onto a bit-cell register array.
// Optional build macro REGFILE_R0_ZERO_EN makes register 0 a hardwired zero.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int WIDTH = REGFILE_WIDTH,
    parameter int NREGS = REGFILE_NREGS
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_access_ctrl_if.slave bus,
    output logic [NREGS-1:0]     wen,
    output logic [NREGS-1:0]     ren1,
    output logic [NREGS-1:0]     ren2,
    output logic [WIDTH-1:0]     d,
    input  logic [WIDTH-1:0]     bl1,
    input  logic [WIDTH-1:0]     bl2
);

    localparam int AW = $clog2(NREGS);

    if ((NREGS < 2) || ((1 << AW) != NREGS)) begin : g_nregs_chk
        $error("regfile_access_ctrl: NREGS must be a power of 2 and at least 2");
    end

    state_t           state;
    state_t           state_nx;
    logic [AW-1:0]    rs1_q;
    logic [AW-1:0]    rs2_q;
    logic [AW-1:0]    rd_q;
    logic             we_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata1_q;
    logic [WIDTH-1:0] rdata2_q;
    logic [WIDTH-1:0] rd1_val;
    logic [WIDTH-1:0] rd2_val;
    logic             ren1_en;
    logic             ren2_en;
    logic             wen_en;
    logic             accept;

    assign bus.req_ready  = (state == ST_IDLE);
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid  = (state == ST_RESP);
    assign bus.rsp_rdata1 = rdata1_q;
    assign bus.rsp_rdata2 = rdata2_q;

`ifdef REGFILE_R0_ZERO_EN
    // Row 0 is never enabled; its reads return zero regardless of the bitline.
    assign ren1_en = (state == ST_READ)  && (rs1_q != '0);
    assign ren2_en = (state == ST_READ)  && (rs2_q != '0);
    assign wen_en  = (state == ST_WRITE) && we_q && (rd_q != '0);
    assign rd1_val = (rs1_q == '0) ? '0 : bl1;
    assign rd2_val = (rs2_q == '0) ? '0 : bl2;
`else
    assign ren1_en = (state == ST_READ);
    assign ren2_en = (state == ST_READ);
    assign wen_en  = (state == ST_WRITE) && we_q;
    assign rd1_val = bl1;
    assign rd2_val = bl2;
`endif

    // Enables and d derive combinationally from state so an async reset drops them at once.
    assign d = (state == ST_WRITE) ? wdata_q : '0;

    regfile_addr_dec #(.AW(AW), .NREGS(NREGS)) u_dec_ren1 (
        .en     (ren1_en),
        .addr   (rs1_q),
        .onehot (ren1)
    );

    regfile_addr_dec #(.AW(AW), .NREGS(NREGS)) u_dec_ren2 (
        .en     (ren2_en),
        .addr   (rs2_q),
        .onehot (ren2)
    );

    regfile_addr_dec #(.AW(AW), .NREGS(NREGS)) u_dec_wen (
        .en     (wen_en),
        .addr   (rd_q),
        .onehot (wen)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = ST_READ;
            ST_READ:  state_nx = ST_WRITE;
            ST_WRITE: state_nx = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rs1_q   <= bus.req_rs1;
                rs2_q   <= bus.req_rs2;
                rd_q    <= bus.req_rd;
                we_q    <= bus.req_we;
                wdata_q <= bus.req_wdata;
            end
            if (state == ST_READ) begin
                rdata1_q <= rd1_val;
                rdata2_q <= rd2_val;
            end
        end
    end

endmodule
